countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Run controller for the countdown timer. It debounces the three front-panel keys and holds the BCD preset.
- It sequences the down-counter through set, run, pause and alarm phases. It issues load pulses and a count enable, and drives the alarm beeper.
- Sits between the raw key inputs and the counter/display path. Consumes the 1 Hz tick from the clock divider and the zero flag from the counter.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised key level must stay stable before it is accepted (20 ms at 50 MHz)
DEFAULT_PRESET, 8'h60, preset loaded at reset, two BCD digits {H,L}
ALARM_SECS, 5, alarm duration in tick_1hz pulses
BEEP_DIV, 25000, clock cycles per beep half-period

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick_1hz  input  1  one-cycle pulse per second from divider
key_start  input  1  raw start/pause key, active-high, asynchronous
key_set  input  1  raw set key, active-high, asynchronous
key_inc  input  1  raw increment key, active-high, asynchronous
count_zero  input  1  counter value is 00
load  output  1  one-cycle pulse: counter loads preset_h/preset_l
preset_h  output  4  preset tens digit, BCD
preset_l  output  4  preset units digit, BCD
count_en  output  1  counter may decrement on tick_1hz
beep  output  1  beeper drive
state  output  3  current FSM state, for display/debug

Behaviour:
- Reset values:
  - state=IDLE(0), preset=DEFAULT_PRESET, load=0, count_en=0, beep=0.
  - Synchronisers, debounce counters, alarm and beep counters cleared.
  - Reset mid-operation aborts any phase immediately.
- Key path, per key:
  - 2-flop synchroniser, then debounce counter. The debounced level updates only after DEBOUNCE_CYCLES consecutive identical samples.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Press latency from a clean raw edge is 2+DEBOUNCE_CYCLES+1 cycles. Glitches shorter than DEBOUNCE_CYCLES produce no press.
- Simultaneous presses in one cycle: start > set > inc. Only the highest-priority press acts; the others are dropped.
- All outputs are registered. load pulses for exactly one cycle, in the cycle after the triggering event.
- States:
  - IDLE(0):
    - start press with preset≠00 -> RUN, load pulse.
    - start press with preset=00 -> stay IDLE, no load.
    - set press -> SET.
  - SET(1):
    - inc press -> preset +1 in BCD: units 9 wraps to 0 with tens carry; 99 wraps to 00.
    - set press -> IDLE, load pulse so the display shows the new preset.
    - start ignored.
  - RUN(2):
    - count_en=1.
    - count_zero=1 -> ALARM, count_en=0 from next cycle.
    - start press -> PAUSE.
    - count_zero has priority over a simultaneous start press.
    - set and inc ignored.
  - PAUSE(3):
    - count_en=0.
    - start press -> RUN.
    - set press -> IDLE, load pulse (abort and reload preset).
  - ALARM(4):
    - beep toggles every BEEP_DIV cycles, starting at 0 on entry.
    - Alarm counter counts tick_1hz pulses. On ALARM_SECS pulses, or any key press, -> IDLE with load pulse, beep=0 the same cycle state leaves ALARM.
- preset changes only in SET. preset_h/preset_l are stable whenever load=1.
- Unused state encodings 5–7 -> IDLE next cycle, outputs at reset values.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BEEP_DIV=3, ALARM_SECS=2, 1 Hz tick modelled as a pulse every 20 cycles.
1. Reset, then hold key_start high 10 cycles -> single load pulse with preset_h=6, preset_l=0, then state=2, count_en=1. A 3-cycle glitch on key_start produces no press.
2. key_set, then 42 inc presses from 60 -> preset wraps 99->00 and ends at 02. Then key_set -> load pulse with 0/2, state=0.
3. Preset 00 in IDLE, press start -> state stays 0, load never pulses.
4. In RUN, press start -> state=3, count_en=0. Press start -> state=2, count_en=1. In PAUSE, press set -> state=0 with load pulse.
5. In RUN, assert count_zero together with a start press -> state=4, count_en=0. beep toggles every 3 cycles. After 2 tick_1hz pulses -> state=0, beep=0, load pulse.
6. Assert reset mid-ALARM and mid-SET -> all outputs at reset values within the same cycle, preset back to 60.

Source files
------------

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - run controller for the countdown timer
//
// Debounces the start/set/inc keys, holds the BCD preset and sequences the
// down-counter through IDLE/SET/RUN/PAUSE/ALARM.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   tick_1hz          one-cycle pulse per second
//   key_start/set/inc raw asynchronous keys, active-high
//   count_zero        counter value is 00
//   load              one-cycle pulse: counter loads preset_h/preset_l
//   preset_h/l        BCD preset digits
//   count_en          counter may decrement on tick_1hz
//   beep              beeper drive
//   state             current FSM state
module countdown_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0] DEFAULT_PRESET  = 8'h60,
    parameter int         ALARM_SECS      = 5,
    parameter int         BEEP_DIV        = 25000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_start,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       count_zero,
    output logic       load,
    output logic [3:0] preset_h,
    output logic [3:0] preset_l,
    output logic       count_en,
    output logic       beep,
    output logic [2:0] state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AL_W = $clog2(ALARM_SECS + 1);
    localparam int BP_W = $clog2(BEEP_DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    state_t st;
    assign state = st;

    // Key path: bit 0 = start, bit 1 = set, bit 2 = inc
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      level;
    logic [2:0]      level_d;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;

    assign raw = {key_inc, key_set, key_start};

    // The debounce counter runs only while the synchronised sample differs
    // from the accepted level; any agreeing sample restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = level & ~level_d;

    // Priority start > set > inc; lower-priority presses are dropped
    logic start_p;
    logic set_p;
    logic inc_p;
    logic any_p;

    assign start_p = press[0];
    assign set_p   = press[1] & ~press[0];
    assign inc_p   = press[2] & ~press[1] & ~press[0];
    assign any_p   = |press;

    // BCD increment with 99 -> 00 wrap
    logic [3:0] next_h;
    logic [3:0] next_l;

    always_comb begin
        next_h = preset_h;
        next_l = preset_l + 4'd1;
        if (preset_l == 4'd9) begin
            next_l = 4'd0;
            next_h = (preset_h == 4'd9) ? 4'd0 : preset_h + 4'd1;
        end
    end

    logic [AL_W-1:0] alarm_cnt;
    logic [BP_W-1:0] beep_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st        <= ST_IDLE;
            preset_h  <= DEFAULT_PRESET[7:4];
            preset_l  <= DEFAULT_PRESET[3:0];
            load      <= 1'b0;
            count_en  <= 1'b0;
            beep      <= 1'b0;
            alarm_cnt <= '0;
            beep_cnt  <= '0;
        end else begin
            load <= 1'b0;
            case (st)
                ST_IDLE: begin
                    count_en <= 1'b0;
                    beep     <= 1'b0;
                    if (start_p) begin
                        if ({preset_h, preset_l} != 8'h00) begin
                            st       <= ST_RUN;
                            load     <= 1'b1;
                            count_en <= 1'b1;
                        end
                    end else if (set_p) begin
                        st <= ST_SET;
                    end
                end

                ST_SET: begin
                    if (inc_p) begin
                        preset_h <= next_h;
                        preset_l <= next_l;
                    end else if (set_p) begin
                        st   <= ST_IDLE;
                        load <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // While load is high the counter still holds its old
                    // value (possibly 00 after an alarm), so its zero flag is
                    // not trusted in that cycle.
                    if (count_zero && !load) begin
                        st        <= ST_ALARM;
                        count_en  <= 1'b0;
                        beep      <= 1'b0;
                        beep_cnt  <= '0;
                        alarm_cnt <= '0;
                    end else if (start_p) begin
                        st       <= ST_PAUSE;
                        count_en <= 1'b0;
                    end
                end

                ST_PAUSE: begin
                    count_en <= 1'b0;
                    if (start_p) begin
                        st       <= ST_RUN;
                        count_en <= 1'b1;
                    end else if (set_p) begin
                        st   <= ST_IDLE;
                        load <= 1'b1;
                    end
                end

                ST_ALARM: begin
                    count_en <= 1'b0;
                    if (any_p || (tick_1hz && alarm_cnt == AL_W'(ALARM_SECS - 1))) begin
                        st        <= ST_IDLE;
                        load      <= 1'b1;
                        beep      <= 1'b0;
                        beep_cnt  <= '0;
                        alarm_cnt <= '0;
                    end else begin
                        if (tick_1hz) begin
                            alarm_cnt <= alarm_cnt + AL_W'(1);
                        end
                        if (beep_cnt == BP_W'(BEEP_DIV - 1)) begin
                            beep     <= ~beep;
                            beep_cnt <= '0;
                        end else begin
                            beep_cnt <= beep_cnt + BP_W'(1);
                        end
                    end
                end

                default: begin
                    st        <= ST_IDLE;
                    load      <= 1'b0;
                    count_en  <= 1'b0;
                    beep      <= 1'b0;
                    alarm_cnt <= '0;
                    beep_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed testbench for countdown_ctrl
module tb_countdown_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_start = 1'b0;
    logic       key_set = 1'b0;
    logic       key_inc = 1'b0;
    logic       count_zero = 1'b0;
    logic       load;
    logic [3:0] preset_h;
    logic [3:0] preset_l;
    logic       count_en;
    logic       beep;
    logic [2:0] state;

    int         checks = 0;
    int         errors = 0;
    int         loads = 0;
    int         l0;
    int         ticks;
    int         n;
    logic [7:0] lp = 8'hxx;

    countdown_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DEFAULT_PRESET (8'h60),
        .ALARM_SECS     (2),
        .BEEP_DIV       (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .key_start (key_start),
        .key_set   (key_set),
        .key_inc   (key_inc),
        .count_zero(count_zero),
        .load      (load),
        .preset_h  (preset_h),
        .preset_l  (preset_l),
        .count_en  (count_en),
        .beep      (beep),
        .state     (state)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            repeat (19) @(posedge clock);
            #1 tick_1hz = 1'b1;
            @(posedge clock);
            #1 tick_1hz = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        if (load === 1'b1) begin
            loads++;
            lp = {preset_h, preset_l};
        end
    endtask

    task automatic press(input int k);
        case (k)
            0: key_start = 1'b1;
            1: key_set   = 1'b1;
            default: key_inc = 1'b1;
        endcase
        repeat (10) cycle();
        key_start = 1'b0;
        key_set   = 1'b0;
        key_inc   = 1'b0;
        repeat (10) cycle();
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_en", 32'(count_en), 32'd0);
        check("rst_beep", 32'(beep), 32'd0);
        check("rst_preset", 32'({preset_h, preset_l}), 32'h60);
        repeat (3) cycle();
        reset = 1'b0;

        // Start from IDLE with default preset
        l0 = loads;
        press(0);
        check("t1_loads", 32'(loads - l0), 32'd1);
        check("t1_preset", 32'(lp), 32'h60);
        check("t1_state", 32'(state), 32'd2);
        check("t1_en", 32'(count_en), 32'd1);

        // Short glitch ignored
        l0 = loads;
        key_start = 1'b1;
        repeat (3) cycle();
        key_start = 1'b0;
        repeat (10) cycle();
        check("t1_glitch_state", 32'(state), 32'd2);
        check("t1_glitch_loads", 32'(loads - l0), 32'd0);

        // Pause / resume / abort
        press(0);
        check("t4_pause_state", 32'(state), 32'd3);
        check("t4_pause_en", 32'(count_en), 32'd0);
        press(0);
        check("t4_resume_state", 32'(state), 32'd2);
        check("t4_resume_en", 32'(count_en), 32'd1);
        press(0);
        l0 = loads;
        press(1);
        check("t4_abort_state", 32'(state), 32'd0);
        check("t4_abort_loads", 32'(loads - l0), 32'd1);
        check("t4_abort_preset", 32'(lp), 32'h60);

        // SET with BCD increments and 99->00 wrap
        press(1);
        check("t2_set_state", 32'(state), 32'd1);
        for (int i = 0; i < 39; i++) press(2);
        check("t2_preset99", 32'({preset_h, preset_l}), 32'h99);
        press(2);
        check("t2_preset00", 32'({preset_h, preset_l}), 32'h00);
        l0 = loads;
        press(1);
        check("t2_exit_state", 32'(state), 32'd0);
        check("t2_exit_loads", 32'(loads - l0), 32'd1);
        check("t2_exit_preset", 32'(lp), 32'h00);

        // Start with preset 00 is refused
        l0 = loads;
        press(0);
        check("t3_state", 32'(state), 32'd0);
        check("t3_loads", 32'(loads - l0), 32'd0);

        // Back to SET, two more incs -> 02
        press(1);
        press(2);
        press(2);
        check("t2_preset02", 32'({preset_h, preset_l}), 32'h02);
        l0 = loads;
        press(1);
        check("t2_load02_loads", 32'(loads - l0), 32'd1);
        check("t2_load02_preset", 32'(lp), 32'h02);
        check("t2_load02_state", 32'(state), 32'd0);

        // RUN, then count_zero together with a start press
        l0 = loads;
        press(0);
        check("t5_run_state", 32'(state), 32'd2);
        check("t5_run_preset", 32'(lp), 32'h02);
        key_start = 1'b1;
        repeat (6) cycle();
        count_zero = 1'b1;
        cycle();
        check("t5_alarm_state", 32'(state), 32'd4);
        check("t5_alarm_en", 32'(count_en), 32'd0);
        ticks = 0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t5_beep%0d", k), 32'(beep), 32'((k / 3) % 2));
            if (tick_1hz) ticks++;
            cycle();
        end
        count_zero = 1'b0;
        key_start = 1'b0;
        l0 = loads;
        n = 0;
        while (ticks < 2 && n < 100) begin
            if (tick_1hz) ticks++;
            if (ticks < 2) begin
                cycle();
                n++;
            end
        end
        check("t5_ticks", 32'(ticks), 32'd2);
        check("t5_pre_exit_state", 32'(state), 32'd4);
        cycle();
        check("t5_exit_state", 32'(state), 32'd0);
        check("t5_exit_beep", 32'(beep), 32'd0);
        check("t5_exit_loads", 32'(loads - l0), 32'd1);
        check("t5_exit_preset", 32'(lp), 32'h02);
        repeat (10) cycle();

        // Reset mid-ALARM
        press(0);
        check("t6_run_state", 32'(state), 32'd2);
        count_zero = 1'b1;
        repeat (2) cycle();
        check("t6_alarm_state", 32'(state), 32'd4);
        reset = 1'b1;
        #1;
        check("t6a_state", 32'(state), 32'd0);
        check("t6a_beep", 32'(beep), 32'd0);
        check("t6a_en", 32'(count_en), 32'd0);
        check("t6a_load", 32'(load), 32'd0);
        check("t6a_preset", 32'({preset_h, preset_l}), 32'h60);
        cycle();
        reset = 1'b0;
        count_zero = 1'b0;

        // Reset mid-SET
        press(1);
        press(2);
        check("t6_set_state", 32'(state), 32'd1);
        check("t6_set_preset", 32'({preset_h, preset_l}), 32'h61);
        reset = 1'b1;
        #1;
        check("t6s_state", 32'(state), 32'd0);
        check("t6s_preset", 32'({preset_h, preset_l}), 32'h60);
        check("t6s_load", 32'(load), 32'd0);
        cycle();
        reset = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
